// File: rtl/demux_1_to_4_reg.sv
// Registered 1-to-4 demultiplexer with valid/ready handshake and a
// single-entry holding register per lane. DEMUX_AUTO_SEL_EN: round-robin lane select.
module demux_1_to_4_reg #(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [1:0]         in_sel,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [4*WIDTH-1:0] out_data,
    output logic [3:0]         out_valid,
    input  logic [3:0]         out_ready
);

    localparam int unsigned LANES = 4;

    logic [1:0] dest;
    logic       accept;

`ifdef DEMUX_AUTO_SEL_EN
    logic [1:0] rr_ptr;
    logic       unused_sel;

    assign unused_sel = ^in_sel;

    // Pointer advances only on an accepted transfer, so rotation stays strictly in order
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= 2'd0;
        end else if (accept) begin
            rr_ptr <= rr_ptr + 2'd1;
        end
    end

    assign dest = rr_ptr;
`else
    assign dest = in_sel;
`endif

    // Destination lane can take a payload if empty or draining this cycle
    assign in_ready = !rst && (!out_valid[dest] || out_ready[dest]);
    assign accept   = in_valid && in_ready;

    // Lane holding registers; data is only written on a load and otherwise holds
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= '0;
            out_data  <= '0;
        end else begin
            for (int k = 0; k < int'(LANES); k++) begin
                if (accept && (dest == 2'(k))) begin
                    out_valid[k]                <= 1'b1;
                    out_data[k*WIDTH +: WIDTH]  <= in_data;
                end else if (out_ready[k]) begin
                    out_valid[k] <= 1'b0;
                end
            end
        end
    end

endmodule
